// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - ALUFun operation codes
//   - FSM state enum for alu_seq (IDLE, MUL, HOLD)
//   - helper for sizing the multiplier iteration counter
package alu_pkg;

    // Adder operations; bit 0 selects subtraction.
    localparam logic [5:0] FUN_ADD  = 6'b000000;
    localparam logic [5:0] FUN_SUB  = 6'b000001;

    // Bitwise logic.
    localparam logic [5:0] FUN_AND  = 6'b011000;
    localparam logic [5:0] FUN_OR   = 6'b011110;
    localparam logic [5:0] FUN_XOR  = 6'b010110;
    localparam logic [5:0] FUN_NOR  = 6'b010001;
    localparam logic [5:0] FUN_PASS = 6'b011010;

    // Shifts: B shifted by A[SHW-1:0].
    localparam logic [5:0] FUN_SLL  = 6'b100000;
    localparam logic [5:0] FUN_SRL  = 6'b100001;
    localparam logic [5:0] FUN_SRA  = 6'b100011;

    // Compares; all have bit 0 set, so the adder subtracts for them.
    localparam logic [5:0] FUN_EQ   = 6'b110011;
    localparam logic [5:0] FUN_NEQ  = 6'b110001;
    localparam logic [5:0] FUN_LT   = 6'b110101;
    localparam logic [5:0] FUN_LEZ  = 6'b111101;
    localparam logic [5:0] FUN_LTZ  = 6'b111011;
    localparam logic [5:0] FUN_GTZ  = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Bits needed to hold the values 0..w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle.
//   clk     in   rising-edge clock
//   reset   in   synchronous active-low reset; aborts any product in progress
//   start   in   load operands and begin (single-cycle pulse)
//   A, B    in   WIDTH-bit operands, sampled only when start is high
//   sign    in   1 = two's-complement product, 0 = unsigned
//   done    out  product valid; high for the one cycle after the last iteration
//   product out  2*WIDTH-bit result
// Takes exactly WIDTH iterations after start. Signed operation sign-extends
// the multiplicand and subtracts (rather than adds) the partial product of
// the multiplier's MSB, since that bit has weight -2^(WIDTH-1).
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               sign,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      count_q;
    logic               busy_q;
    logic               sign_q;
    logic               last_iter;

    assign last_iter = (count_q == CW'(1));

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            if (last_iter && sign_q) begin
                acc_d = acc_q - mcand_q;
            end else begin
                acc_d = acc_q + mcand_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            sign_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{sign & A[WIDTH-1]}}, A};
            mplier_q <= B;
            count_q  <= CW'(WIDTH);
            busy_q   <= 1'b1;
            sign_q   <= sign;
        end else if (busy_q) begin
            if (count_q != '0) begin
                acc_q    <= acc_d;
                mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                count_q  <= count_q - CW'(1);
            end else begin
                // Result consumed this cycle.
                busy_q <= 1'b0;
            end
        end
    end

    assign done    = busy_q && (count_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes on input and output.
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   in_valid   in   operation offered
//   in_ready   out  operation accepted when in_valid && in_ready at an edge
//   A, B       in   WIDTH-bit operands
//   ALUFun     in   6-bit operation code (see alu_pkg)
//   sign       in   signed arithmetic / compare / multiply
//   md         in   multiply request; ALUFun ignored
//   out_valid  out  result available
//   out_ready  in   result taken when out_valid && out_ready at an edge
//   S, HI      out  result; HI is the upper half of a product, else 0
//   Z, V, N    out  adder flags of the accepted operation (0 for multiply)
// Single-cycle ops are computed combinationally at acceptance and registered,
// so a result appears the cycle after acceptance. Multiplies go to
// alu_mul_iter and present their result WIDTH+1 cycles after acceptance.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       ALUFun,
    input  logic             sign,
    input  logic             md,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] HI,
    output logic             Z,
    output logic             V,
    output logic             N
);

    state_t state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             z_q, z_d;
    logic             v_q, v_d;
    logic             n_q, n_d;

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;

    // ------------------------------------------------------------------
    // Adder: subtracts when ALUFun[0] is set (SUB and all two-operand compares).
    // ------------------------------------------------------------------
    logic             sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic             add_ovf;
    logic             add_z;
    logic             add_n;
    logic             add_v;
    logic             lt_bit;

    assign sub       = ALUFun[0];
    assign b_op      = sub ? ~B : B;
    assign add_full  = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    assign add_sum   = add_full[WIDTH-1:0];
    assign add_carry = add_full[WIDTH];
    assign add_ovf   = (A[WIDTH-1] == b_op[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
    assign add_z     = (add_sum == '0);
    assign add_n     = add_sum[WIDTH-1];
    // Unsigned: carry for add, borrow (inverted carry) for subtract.
    assign add_v     = sign ? add_ovf : (add_carry ^ sub);
    assign lt_bit    = sign ? (add_n ^ add_ovf) : ~add_carry;

    // ------------------------------------------------------------------
    // Shifter and zero tests on A.
    // ------------------------------------------------------------------
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sll_res;
    logic [WIDTH-1:0] srl_res;
    logic [WIDTH-1:0] sra_res;
    logic             a_zero;
    logic             a_neg;

    assign shamt   = A[SHW-1:0];
    assign sll_res = B << shamt;
    assign srl_res = B >> shamt;
    assign sra_res = $signed(B) >>> shamt;
    assign a_zero  = (A == '0);
    assign a_neg   = A[WIDTH-1];

    // ------------------------------------------------------------------
    // Result mux for single-cycle operations.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] res;

    always_comb begin
        res = '0;
        case (ALUFun)
            FUN_ADD,
            FUN_SUB:  res = add_sum;
            FUN_AND:  res = A & B;
            FUN_OR:   res = A | B;
            FUN_XOR:  res = A ^ B;
            FUN_NOR:  res = ~(A | B);
            FUN_PASS: res = A;
            FUN_SLL:  res = sll_res;
            FUN_SRL:  res = srl_res;
            FUN_SRA:  res = sra_res;
            FUN_EQ:   res = {{(WIDTH-1){1'b0}}, add_z};
            FUN_NEQ:  res = {{(WIDTH-1){1'b0}}, ~add_z};
            FUN_LT:   res = {{(WIDTH-1){1'b0}}, lt_bit};
            FUN_LEZ:  res = {{(WIDTH-1){1'b0}}, a_neg | a_zero};
            FUN_LTZ:  res = {{(WIDTH-1){1'b0}}, a_neg};
            FUN_GTZ:  res = {{(WIDTH-1){1'b0}}, ~a_neg & ~a_zero};
            default:  res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and multiplier launch.
    // ------------------------------------------------------------------
    // reset gates in_ready so nothing is accepted while reset is held.
    assign in_ready  = reset && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && md;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .A       (A),
        .B       (B),
        .sign    (sign),
        .done    (mul_done),
        .product (mul_product)
    );

    // ------------------------------------------------------------------
    // FSM next state and output registers.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        s_d         = s_q;
        hi_d        = hi_q;
        z_d         = z_q;
        v_d         = v_q;
        n_d         = n_q;

        case (state_q)
            IDLE: begin
                if (accept && md) begin
                    // Any previous result was handshaken this cycle.
                    state_d     = MUL;
                    out_valid_d = 1'b0;
                end else if (accept) begin
                    // Replaces a result taken this same cycle without a bubble.
                    out_valid_d = 1'b1;
                    s_d         = res;
                    hi_d        = '0;
                    z_d         = add_z;
                    v_d         = add_v;
                    n_d         = add_n;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end else if (out_valid_q) begin
                    state_d = HOLD;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    s_d         = mul_product[WIDTH-1:0];
                    hi_d        = mul_product[2*WIDTH-1:WIDTH];
                    z_d         = 1'b0;
                    v_d         = 1'b0;
                    n_d         = 1'b0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            hi_q        <= '0;
            z_q         <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            hi_q        <= hi_d;
            z_q         <= z_d;
            v_q         <= v_d;
            n_q         <= n_d;
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign HI        = hi_q;
    assign Z         = z_q;
    assign V         = v_q;
    assign N         = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes hand-computed expected
// results at acceptance; a monitor pops and compares on each output handshake.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready;
    logic [W-1:0] A, B;
    logic [5:0]   ALUFun;
    logic         sign, md;
    logic         out_valid, out_ready;
    logic [W-1:0] S, HI;
    logic         Z, V, N;

    logic         d8_in_valid, d8_in_ready, d8_out_valid;
    logic [7:0]   d8_A, d8_B, d8_S, d8_HI;
    logic [5:0]   d8_ALUFun;
    logic         d8_Z, d8_V, d8_N;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUFun(ALUFun), .sign(sign), .md(md),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .HI(HI), .Z(Z), .V(V), .N(N)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .A(d8_A), .B(d8_B), .ALUFun(d8_ALUFun), .sign(1'b0), .md(1'b0),
        .out_valid(d8_out_valid), .out_ready(1'b1),
        .S(d8_S), .HI(d8_HI), .Z(d8_Z), .V(d8_V), .N(d8_N)
    );

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] hi;
        logic [2:0]   zvn;
        bit           chk_flags;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got S=%0h HI=%0h expected no result", S, HI);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_S"}, 64'(S), 64'(e.s));
                    check({e.name, "_HI"}, 64'(HI), 64'(e.hi));
                    if (e.chk_flags) check({e.name, "_ZVN"}, 64'({Z, V, N}), 64'(e.zvn));
                end
            end
        end
    end

    // Drive one operation, wait (bounded) for acceptance, push expectation.
    task automatic issue(input string name, input logic [5:0] fun, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sg, input logic m,
                         input logic [W-1:0] es, input logic [W-1:0] ehi,
                         input logic [2:0] ezvn, input bit cf, input bit push,
                         output int waited);
        exp_t e;
        in_valid = 1'b1;
        ALUFun   = fun;
        A        = a;
        B        = b;
        sign     = sg;
        md       = m;
        waited   = 0;
        #1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got in_ready=0 expected acceptance", name);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.s = es; e.hi = ehi; e.zvn = ezvn; e.chk_flags = cf; e.name = name;
            sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic op(input string name, input logic [5:0] fun, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic sg, input logic [W-1:0] es);
        int w;
        issue(name, fun, a, b, sg, 1'b0, es, '0, 3'b000, 1'b0, 1'b1, w);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic mul_latency(input string name);
        int n;
        bit ir_bad;
        n = 0;
        ir_bad = 1'b0;
        #1;
        while (!out_valid && n < 200) begin
            if (in_ready) ir_bad = 1'b1;
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(W + 1));
        check({name, "_in_ready_low"}, 64'(ir_bad), 64'd0);
    endtask

    initial begin
        int w;
        bit seen;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; ALUFun = '0; sign = 1'b0; md = 1'b0;
        d8_in_valid = 1'b0; d8_A = '0; d8_B = '0; d8_ALUFun = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_S_HI", {S, HI}, 64'd0);
        check("rst_ZVN", 64'({Z, V, N}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Signed overflow on ADD, result one cycle after acceptance.
        issue("add_ovf", FUN_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0,
              32'h8000_0000, '0, 3'b011, 1'b1, 1'b1, w);
        #1 check("add_latency", 64'(out_valid), 64'd1);
        @(negedge clk);
        idle(1);

        // Back-to-back SUB / LT unsigned / LT signed.
        issue("sub_eq", FUN_SUB, 32'd5, 32'd5, 1'b1, 1'b0, '0, '0, 3'b100, 1'b1, 1'b1, w);
        issue("lt_u", FUN_LT, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, '0, '0, 3'b000, 1'b0, 1'b1, w);
        check("lt_u_no_bubble", 64'(w), 64'd0);
        issue("lt_s", FUN_LT, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'd1, '0, 3'b000, 1'b0, 1'b1,
              w);
        check("lt_s_no_bubble", 64'(w), 64'd0);

        // Logic, shifts, compares, unknown code.
        op("and",  FUN_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'h00F0_1200);
        op("or",   FUN_OR,   32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'hFFF0_FF34);
        op("xor",  FUN_XOR,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'hFF00_ED34);
        op("nor",  FUN_NOR,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'h000F_00CB);
        op("pass", FUN_PASS, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'hF0F0_1234);
        op("sll",  FUN_SLL,  32'h0000_0024, 32'h0000_0001, 1'b0, 32'h0000_0010);
        op("srl",  FUN_SRL,  32'h0000_0008, 32'h8000_0000, 1'b0, 32'h0080_0000);
        op("eq",   FUN_EQ,   32'd7, 32'd7, 1'b0, 32'd1);
        op("neq",  FUN_NEQ,  32'd7, 32'd7, 1'b0, 32'd0);
        op("lez0", FUN_LEZ,  32'd0, 32'd9, 1'b1, 32'd1);
        op("ltz0", FUN_LTZ,  32'd0, 32'd9, 1'b1, 32'd0);
        op("gtz5", FUN_GTZ,  32'd5, 32'd0, 1'b1, 32'd1);
        op("gtzn", FUN_GTZ,  32'h8000_0000, 32'd0, 1'b1, 32'd0);
        op("bad",  6'b101010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);

        // Unsigned carry and borrow flags.
        issue("addu_c", FUN_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, '0, '0, 3'b110, 1'b1, 1'b1, w);
        issue("subu_b", FUN_SUB, 32'd1, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, '0, 3'b011, 1'b1,
              1'b1, w);
        idle(2);

        // Multiplies; operands changed right after acceptance must not matter.
        issue("mul_s", 6'b101010, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1,
              32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b000, 1'b1, 1'b1, w);
        A = 32'h1234; B = 32'd7; sign = 1'b0;
        mul_latency("mul_s");
        issue("mul_u", FUN_ADD, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1,
              32'hFFFF_FFFE, 32'h1, 3'b000, 1'b1, 1'b1, w);
        mul_latency("mul_u");
        issue("mul_nn", FUN_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1,
              32'h1, 32'h0, 3'b000, 1'b1, 1'b1, w);
        idle(40);

        // Output stall: result and in_ready held, then released with a new op.
        issue("sra", FUN_SRA, 32'd4, 32'h8000_0000, 1'b0, 1'b0, 32'hF800_0000, '0, 3'b000,
              1'b0, 1'b1, w);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_S", 64'(S), 64'hF800_0000);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        op("after_stall", FUN_ADD, 32'd1, 32'd2, 1'b0, 32'd3);
        idle(3);

        // Reset during a multiply: silently aborted.
        issue("mul_abort", FUN_ADD, 32'd3, 32'd5, 1'b0, 1'b1, '0, '0, 3'b000, 1'b0, 1'b0, w);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("abort_rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1 check("abort_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_out", 64'(seen), 64'd0);

        // WIDTH=8: shift amount comes from A[2:0].
        @(negedge clk);
        d8_in_valid = 1'b1; d8_A = 8'h0B; d8_B = 8'h01; d8_ALUFun = FUN_SLL;
        #1 check("w8_in_ready", 64'(d8_in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        d8_in_valid = 1'b0;
        #1;
        check("w8_valid", 64'(d8_out_valid), 64'd1);
        check("w8_S", 64'(d8_S), 64'h08);
        check("w8_HI", 64'(d8_HI), 64'h00);

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have one clock and a synchronous, active-low reset, named as the codebase does: port clk, port reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  operation accepted when in_valid and in_ready are both high at a rising edge.
REQ-008 A, B  input  WIDTH each  operands.
REQ-009 ALUFun  input  6  operation code; encodings in REQ-016.
REQ-010 sign  input  1  1 = signed arithmetic, compare and multiply; 0 = unsigned.
REQ-011 md  input  1  1 = multiply request; ALUFun is ignored.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer takes the result when out_valid and out_ready are both high at a rising edge.
REQ-014 S, HI  output  WIDTH each  result; HI carries the product's upper half.
REQ-015 Z, V, N  output  1 each  registered adder flags for the accepted operation.

Function
REQ-016 ALUFun encodings:
- ADD 000000, SUB 000001
- AND 011000, OR 011110, XOR 010110, NOR 010001, PASS-A 011010
- SLL 100000, SRL 100001, SRA 100011
- EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111
REQ-017 Any other code SHALL yield S=0, HI=0.
REQ-018 Adder: S=A+B or A-B modulo 2^WIDTH.
- Z = result zero; N = result MSB.
- V = signed overflow when sign=1; carry/borrow out when sign=0.
REQ-019 Shifts: S = B shifted by A[SHW-1:0].
REQ-020 Compares: S = zero-extended 1-bit result.
- LT uses N^V (sign=1) or borrow (sign=0).
- LEZ/LTZ/GTZ test A against zero (signed).
REQ-021 HI SHALL be 0 for every non-multiply operation.
REQ-022 Multiply: {HI,S} = full 2*WIDTH-bit product A*B, signed when sign=1, unsigned otherwise; Z, V, N = 0.
REQ-023 FSM states IDLE, MUL, HOLD.
- IDLE: accepts operations.
- MUL: entered on accepting md=1; runs exactly WIDTH cycles; then raises out_valid and returns to IDLE.
- HOLD: entered when out_valid is high and out_ready is low; returns to IDLE on the handshake.
REQ-024 in_ready = (state==IDLE) and (!out_valid or out_ready).
REQ-025 A non-md operation accepted at edge T SHALL produce out_valid=1 from edge T+1.
REQ-026 Throughput with out_ready held high SHALL be one non-md result per cycle.
REQ-027 A multiply accepted at edge T SHALL raise out_valid at edge T+WIDTH+1; in_ready=0 throughout.
REQ-028 S, HI, Z, V, N SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 Operands and mode SHALL be captured at acceptance; later input changes SHALL not affect an operation in flight.
REQ-030 On a simultaneous output handshake and new acceptance in one cycle, the new result SHALL replace the old one with no bubble.
REQ-031 out_valid SHALL fall after a handshake when no new operation was accepted.

Reset
REQ-032 With reset low at an edge: state=IDLE; out_valid=0; S, HI, Z, V, N = 0; multiply counter=0.
REQ-033 Reset mid-multiply SHALL abort the operation silently; no result is ever presented.
REQ-034 in_ready SHALL be 0 while reset is low and 1 on the first cycle after release.

Structure
REQ-035 Package alu_pkg SHALL hold the ALUFun constants and the state enum (IDLE, MUL, HOLD).
REQ-036 The iterative shift-add multiplier SHALL be sub-module alu_mul_iter.
- Ports: start, A, B, sign, done, 2*WIDTH product.
- Iteration count: WIDTH.
REQ-037 Combinational datapath (adder, logic, shift, compare) and the result mux SHALL remain in alu_seq.

Verification
REQ-038 WIDTH=32, sign=1, ADD A=0x7FFFFFFF B=1 -> one cycle later out_valid=1, S=0x80000000, V=1, N=1, Z=0.
REQ-039 SUB A=5 B=5, then LT A=0xFFFFFFFF B=1 with sign=0 and then sign=1, issued back-to-back with out_ready=1 -> results 0 (Z=1), 0, 1 on consecutive cycles.
REQ-040 Multiply A=0xFFFFFFFF B=2:
- sign=1 -> after 33 cycles HI=0xFFFFFFFF, S=0xFFFFFFFE.
- sign=0 -> HI=1, S=0xFFFFFFFE.
- in_ready=0 throughout.
REQ-041 out_ready=0 for 5 cycles after SRA A=4 B=0x80000000 -> S=0xF8000000 stable, in_ready=0; drop and stall released together with a new in_valid -> no bubble.
REQ-042 reset low at cycle 10 of a multiply -> out_valid never rises, in_ready=1 the cycle after release.
REQ-043 WIDTH=8, SLL A=0x0B B=0x01 -> S=0x08 (shift amount 3 taken from A[2:0]).
